// File: rtl/maze_pkg.sv
// Shared definitions for the maze game: direction codes, tile codes and the
// direction conditioner state encoding, reused by the movement stage.
package maze_pkg;

  localparam logic [3:0] DIR_NONE  = 4'b0000;
  localparam logic [3:0] DIR_UP    = 4'b0001;
  localparam logic [3:0] DIR_DOWN  = 4'b0010;
  localparam logic [3:0] DIR_RIGHT = 4'b0100;
  localparam logic [3:0] DIR_LEFT  = 4'b1000;

  localparam logic TILE_FLOOR = 1'b0;
  localparam logic TILE_WALL  = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PULSE = 2'd1,
    ST_GAP   = 2'd2
  } dir_state_t;

  // True when exactly one of the four key levels is set.
  function automatic logic is_one_hot4(input logic [3:0] v);
    return (v != 4'b0000) && ((v & (v - 4'b0001)) == 4'b0000);
  endfunction

endpackage

// File: rtl/key_debouncer.sv
// One pushbutton: 2-flop synchronizer, inversion to active-high and a
// consecutive-disagreement counter that moves the debounced level.
module key_debouncer #(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic i_clock,
  input  logic i_reset,
  input  logic i_key_n,
  output logic o_key_held
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic          r_sync1;
  logic          r_sync2;
  logic          r_held;
  logic [CW-1:0] r_cnt;
  logic          w_level;

  assign w_level    = ~r_sync2;
  assign o_key_held = r_held;

  // Synchronizer idles at the released (high) level.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= i_key_n;
      r_sync2 <= r_sync1;
    end
  end

  // The count stops at CNT_LAST, where the level flips, so it can never wrap.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_held <= 1'b0;
      r_cnt  <= '0;
    end else if (w_level == r_held) begin
      r_cnt <= '0;
    end else if (r_cnt >= CNT_LAST) begin
      r_held <= w_level;
      r_cnt  <= '0;
    end else begin
      r_cnt <= r_cnt + CNT_ONE;
    end
  end

endmodule

// File: rtl/direction_conditioner.sv
// Turns four raw active-low direction buttons into fixed-length one-hot
// direction pulses with optional auto-repeat while a single key is held.
module direction_conditioner
  import maze_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int PULSE_CYCLES    = 8,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000,
  parameter bit REPEAT_EN       = 1'b1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] key_n,
  output logic [3:0] player_direction,
  output logic       press_strobe,
  output logic [3:0] keys_held
);

  localparam int TMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int TW   = $clog2(TMAX + 1);
  localparam int PW   = $clog2(PULSE_CYCLES);
  localparam logic [TW-1:0] T_DELAY  = TW'(REPEAT_DELAY);
  localparam logic [TW-1:0] T_PERIOD = TW'(REPEAT_PERIOD);
  localparam logic [TW-1:0] T_ONE    = TW'(1);
  localparam logic [PW-1:0] P_LAST   = PW'(PULSE_CYCLES - 1);
  localparam logic [PW-1:0] P_ONE    = PW'(1);

  logic [3:0]    w_held;
  logic          w_req;
  dir_state_t    r_state, w_state_next;
  logic [3:0]    r_dir_latched, w_dir_latched_next;
  logic          r_repeat, w_repeat_next;
  logic [PW-1:0] r_pcnt, w_pcnt_next;
  logic [TW-1:0] r_timer, w_timer_next;
  logic [3:0]    w_dir_out, r_dir_out;
  logic          w_strobe_out, r_strobe;

  for (genvar g = 0; g < 4; g++) begin : g_key
    key_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_debouncer (
      .i_clock    (clock),
      .i_reset    (reset),
      .i_key_n    (key_n[g]),
      .o_key_held (w_held[g])
    );
  end

  assign w_req            = is_one_hot4(w_held);
  assign keys_held        = w_held;
  assign player_direction = r_dir_out;
  assign press_strobe     = r_strobe;

  // State register with latched direction, repeat flag, pulse counter and gap timer.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state       <= ST_IDLE;
      r_dir_latched <= DIR_NONE;
      r_repeat      <= 1'b0;
      r_pcnt        <= '0;
      r_timer       <= '0;
    end else begin
      r_state       <= w_state_next;
      r_dir_latched <= w_dir_latched_next;
      r_repeat      <= w_repeat_next;
      r_pcnt        <= w_pcnt_next;
      r_timer       <= w_timer_next;
    end
  end

  // Next-state logic; in GAP a release or key change beats timer expiry.
  always_comb begin
    w_state_next       = r_state;
    w_dir_latched_next = r_dir_latched;
    w_repeat_next      = r_repeat;
    w_pcnt_next        = r_pcnt;
    w_timer_next       = r_timer;
    case (r_state)
      ST_IDLE: begin
        if (w_req) begin
          w_state_next       = ST_PULSE;
          w_dir_latched_next = w_held;
          w_repeat_next      = 1'b0;
          w_pcnt_next        = '0;
        end else begin
          w_state_next = ST_IDLE;
        end
      end
      ST_PULSE: begin
        if (r_pcnt == P_LAST) begin
          w_state_next = ST_GAP;
          w_timer_next = r_repeat ? T_PERIOD : T_DELAY;
        end else begin
          w_pcnt_next = r_pcnt + P_ONE;
        end
      end
      ST_GAP: begin
        if (w_held != r_dir_latched) begin
          w_state_next = ST_IDLE;
        end else if (REPEAT_EN && (r_timer <= T_ONE)) begin
          w_state_next  = ST_PULSE;
          w_repeat_next = 1'b1;
          w_pcnt_next   = '0;
        end else if (r_timer != '0) begin
          w_timer_next = r_timer - T_ONE;
        end else begin
          w_timer_next = r_timer;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // Outputs are decoded from the next state so the registered copy lines up with the state.
  always_comb begin
    w_dir_out    = DIR_NONE;
    w_strobe_out = 1'b0;
    if (w_state_next == ST_PULSE) begin
      w_dir_out    = w_dir_latched_next;
      w_strobe_out = (r_state != ST_PULSE);
    end else begin
      w_dir_out    = DIR_NONE;
      w_strobe_out = 1'b0;
    end
  end

  // Output registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_dir_out <= DIR_NONE;
      r_strobe  <= 1'b0;
    end else begin
      r_dir_out <= w_dir_out;
      r_strobe  <= w_strobe_out;
    end
  end

endmodule
